otter_pipe_ctrl: RTL
====================

Name: otter_pipe_ctrl

Overview:
- Central hazard, flush and trap sequencer for the 5-stage OTTER pipeline (fetch, decode, execute, memory, writeback).
- Compares register addresses across stages and generates ALU operand forwarding selects.
- Inserts load-use stalls and squashes wrong-path instructions after execute-resolved redirects.
- Drains the pipeline and steers the PC to mtvec on interrupt entry.

Parameters:
DRAIN_CYCLES, 3, cycles the pipeline drains between interrupt acceptance and trap entry (1..7)

Ports:
CLK  in  1  clock
RST  in  1  asynchronous reset, active-low
DE_VALID  in  1  decode stage holds a real instruction
DE_PC  in  32  PC of the decode-stage instruction
DE_RS1  in  5  decode rs1 address
DE_RS2  in  5  decode rs2 address
DE_USE_RS1  in  1  decode instruction reads rs1
DE_USE_RS2  in  1  decode instruction reads rs2
EX_RD  in  5  execute destination register
EX_REGWRITE  in  1  execute instruction writes the RF
EX_IS_LOAD  in  1  execute instruction is a load
EX_REDIRECT  in  1  execute resolved a taken branch, jal, jalr or mret
MEM_RD  in  5  memory-stage destination register
MEM_REGWRITE  in  1  memory-stage instruction writes the RF
WB_RD  in  5  writeback destination register
WB_REGWRITE  in  1  writeback instruction writes the RF
INT_REQ  in  1  level interrupt (INT & mie)
PC_WRITE  out  1  PC load enable
PC_SEL  out  2  0 = pc+4, 1 = execute redirect target, 2 = mtvec
DE_EN  out  1  IF/DE register enable
FLUSH_DE  out  1  IF/DE register loads a nop (0x00000013)
FLUSH_EX  out  1  DE/EX register loads a nop
FWD_A  out  2  execute operand A: 0 = RF, 1 = memory-stage ALU result, 2 = writeback data
FWD_B  out  2  execute operand B: same encoding as FWD_A
INT_TAKEN  out  1  one-cycle pulse to CSR; sets mepc, clears mie
EPC  out  32  return address for CSR mepc

Behaviour:
- Reset (RST low, asynchronous): state = RUN, drain counter = 0, EPC = 0, INT_TAKEN = 0. Other outputs take their RUN-state combinational defaults.
- States: RUN, BUBBLE, DRAIN, ENTER.
- Forwarding: combinational, active in every state.
  - FWD_A = 1 if MEM_REGWRITE & MEM_RD != 0 & MEM_RD == execute rs1 (registered internally from DE_RS1 when the DE/EX register advances).
  - Otherwise FWD_A = 2 if the same test matches on WB_RD / WB_REGWRITE.
  - Otherwise FWD_A = 0. The memory stage has priority over writeback; x0 is never forwarded.
  - FWD_B uses the same rules with rs2. A flushed DE/EX slot clears its stored source addresses to 0.
- RUN, evaluated in priority order:
  1. EX_REDIRECT: PC_WRITE = 1, PC_SEL = 1, FLUSH_DE = 1, FLUSH_EX = 1; next state BUBBLE.
  2. Load-use (EX_IS_LOAD & EX_REGWRITE & EX_RD != 0, and EX_RD matches DE_RS1 with DE_USE_RS1 or DE_RS2 with DE_USE_RS2): PC_WRITE = 0, DE_EN = 0, FLUSH_EX = 1. Exactly one bubble; stays in RUN.
  3. INT_REQ & DE_VALID: capture EPC = DE_PC, PC_WRITE = 0, FLUSH_DE = 1, FLUSH_EX = 1, counter = DRAIN_CYCLES - 1; next state DRAIN.
  4. Otherwise: PC_WRITE = 1, PC_SEL = 0, DE_EN = 1, no flush.
- BUBBLE: FLUSH_DE = 1 (squashes the wrong-path word from the synchronous fetch memory), PC_WRITE = 1, PC_SEL = 0; next state RUN. Interrupts are not accepted here.
- DRAIN: PC_WRITE = 0, FLUSH_DE = 1, FLUSH_EX = 1; counter decrements; at 0, next state ENTER.
  - An EX_REDIRECT seen in DRAIN is ignored, because the execute slot holds a nop.
- ENTER: INT_TAKEN = 1, PC_WRITE = 1, PC_SEL = 2, FLUSH_DE = 1; next state BUBBLE. EPC is held until the next accepted interrupt.
- Boundary cases:
  - EX_REDIRECT together with load-use or INT_REQ: the redirect wins.
  - INT_REQ deasserting during DRAIN: entry still completes.
  - INT_REQ held high after ENTER: re-accepted only in RUN with DE_VALID. CSR clearing mie is what prevents re-entry.
  - Reset asserted in any state returns to RUN within the same cycle.
- Latency:
  - Redirect penalty: 2 cycles.
  - Load-use penalty: 1 cycle.
  - Interrupt: DRAIN_CYCLES + 1 cycles from acceptance to mtvec fetch.

Test Plan:
1. Memory stage writes x5, decode→execute reads x5 as rs1 while writeback also writes x5 → FWD_A = 1. MEM_RD = 0 with WB_RD = 0 → FWD_A = 0.
2. EX_IS_LOAD, EX_RD = 7, DE_RS2 = 7, DE_USE_RS2 → one cycle of PC_WRITE = 0, DE_EN = 0, FLUSH_EX = 1; next cycle PC_WRITE = 1. Repeat with DE_USE_RS2 = 0 → no stall.
3. EX_REDIRECT pulse → cycle N: PC_SEL = 1, FLUSH_DE = FLUSH_EX = 1; cycle N+1: FLUSH_DE = 1, PC_SEL = 0; cycle N+2: no flush.
4. INT_REQ with DE_VALID, DE_PC = 0x100, DRAIN_CYCLES = 3 → three DRAIN cycles, then INT_TAKEN = 1 with PC_SEL = 2 and EPC = 0x100, then one BUBBLE cycle.
5. EX_REDIRECT, load-use and INT_REQ in the same cycle → redirect sequence only. The interrupt is accepted on the first RUN cycle after BUBBLE.
6. RST low mid-DRAIN → immediately state RUN, INT_TAKEN = 0, EPC = 0. After release, normal fetch with PC_SEL = 0.

Source files
------------

// File: rtl/otter_pipe_ctrl.sv
// Hazard, flush and trap sequencer for the 5-stage OTTER pipeline.
// Forwarding selects are combinational; the sequencer owns redirect, load-use and interrupt entry.
module otter_pipe_ctrl #(
    parameter int DRAIN_CYCLES = 3
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        DE_VALID,
    input  logic [31:0] DE_PC,
    input  logic [4:0]  DE_RS1,
    input  logic [4:0]  DE_RS2,
    input  logic        DE_USE_RS1,
    input  logic        DE_USE_RS2,
    input  logic [4:0]  EX_RD,
    input  logic        EX_REGWRITE,
    input  logic        EX_IS_LOAD,
    input  logic        EX_REDIRECT,
    input  logic [4:0]  MEM_RD,
    input  logic        MEM_REGWRITE,
    input  logic [4:0]  WB_RD,
    input  logic        WB_REGWRITE,
    input  logic        INT_REQ,
    output logic        PC_WRITE,
    output logic [1:0]  PC_SEL,
    output logic        DE_EN,
    output logic        FLUSH_DE,
    output logic        FLUSH_EX,
    output logic [1:0]  FWD_A,
    output logic [1:0]  FWD_B,
    output logic        INT_TAKEN,
    output logic [31:0] EPC
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_BUBBLE,
        ST_DRAIN,
        ST_ENTER
    } state_e;

    localparam logic [1:0] PC_SEL_SEQ   = 2'd0;
    localparam logic [1:0] PC_SEL_REDIR = 2'd1;
    localparam logic [1:0] PC_SEL_TRAP  = 2'd2;

    localparam logic [1:0] FWD_RF  = 2'd0;
    localparam logic [1:0] FWD_MEM = 2'd1;
    localparam logic [1:0] FWD_WB  = 2'd2;

    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);

    state_e      state_q,     state_d;
    logic [2:0]  cnt_q,       cnt_d;
    logic [31:0] epc_q,       epc_d;
    logic        int_taken_q, int_taken_d;
    logic [4:0]  ex_rs1_q,    ex_rs1_d;
    logic [4:0]  ex_rs2_q,    ex_rs2_d;

    logic load_use;

    // Memory stage is younger than writeback, so it wins; x0 is hardwired and never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] src,
        input logic [4:0] mem_rd,
        input logic       mem_we,
        input logic [4:0] wb_rd,
        input logic       wb_we
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == src)) begin
            return FWD_MEM;
        end else if (wb_we && (wb_rd != 5'd0) && (wb_rd == src)) begin
            return FWD_WB;
        end
        return FWD_RF;
    endfunction

    assign FWD_A = fwd_sel(ex_rs1_q, MEM_RD, MEM_REGWRITE, WB_RD, WB_REGWRITE);
    assign FWD_B = fwd_sel(ex_rs2_q, MEM_RD, MEM_REGWRITE, WB_RD, WB_REGWRITE);

    assign load_use = EX_IS_LOAD && EX_REGWRITE && (EX_RD != 5'd0) &&
                      ((DE_USE_RS1 && (EX_RD == DE_RS1)) ||
                       (DE_USE_RS2 && (EX_RD == DE_RS2)));

    assign INT_TAKEN = int_taken_q;
    assign EPC       = epc_q;

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        epc_d    = epc_q;
        PC_WRITE = 1'b1;
        PC_SEL   = PC_SEL_SEQ;
        DE_EN    = 1'b1;
        FLUSH_DE = 1'b0;
        FLUSH_EX = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                if (EX_REDIRECT) begin
                    PC_SEL   = PC_SEL_REDIR;
                    FLUSH_DE = 1'b1;
                    FLUSH_EX = 1'b1;
                    state_d  = ST_BUBBLE;
                end else if (load_use) begin
                    PC_WRITE = 1'b0;
                    DE_EN    = 1'b0;
                    FLUSH_EX = 1'b1;
                end else if (INT_REQ && DE_VALID) begin
                    epc_d    = DE_PC;
                    PC_WRITE = 1'b0;
                    FLUSH_DE = 1'b1;
                    FLUSH_EX = 1'b1;
                    cnt_d    = DRAIN_INIT;
                    state_d  = ST_DRAIN;
                end
            end
            // The synchronous fetch memory still returns the word for the old PC here.
            ST_BUBBLE: begin
                FLUSH_DE = 1'b1;
                state_d  = ST_RUN;
            end
            ST_DRAIN: begin
                PC_WRITE = 1'b0;
                FLUSH_DE = 1'b1;
                FLUSH_EX = 1'b1;
                if (cnt_q == 3'd0) begin
                    state_d = ST_ENTER;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_ENTER: begin
                PC_SEL   = PC_SEL_TRAP;
                FLUSH_DE = 1'b1;
                state_d  = ST_BUBBLE;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        int_taken_d = (state_d == ST_ENTER);

        // A squashed DE/EX slot must not look like a reader of any real register.
        ex_rs1_d = FLUSH_EX ? 5'd0 : DE_RS1;
        ex_rs2_d = FLUSH_EX ? 5'd0 : DE_RS2;
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= ST_RUN;
            cnt_q       <= 3'd0;
            epc_q       <= 32'd0;
            int_taken_q <= 1'b0;
            ex_rs1_q    <= 5'd0;
            ex_rs2_q    <= 5'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            epc_q       <= epc_d;
            int_taken_q <= int_taken_d;
            ex_rs1_q    <= ex_rs1_d;
            ex_rs2_q    <= ex_rs2_d;
        end
    end

endmodule
